// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_bus_arbiter_pkg                                       |
// | Brief    : Shared state encoding, owner constants, wait-counter      |
// |            limits and latched-request type for the D-bus arbiter.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mem_bus_arbiter_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Bus owner encoding
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  // Wait-state counter: 4 bits covers the 0..15 latency range
  localparam int unsigned WAIT_CYCLES_MAX = 15;
  localparam int unsigned CNT_W           = 4;

  // Request captured at grant; read is implied by wr == 0
  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_arb_pick                                              |
// | Brief    : Combinational owner selection for the D-bus arbiter.      |
// |            ARB_ROUND_ROBIN_EN defined: simultaneous requests go to   |
// |            the master not served last. Undefined: core always wins.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic core_req_i,
  input  logic dma_req_i,
  input  logic last_owner_i,
  output logic owner_o
);

`ifdef ARB_ROUND_ROBIN_EN
  // Contention alternates away from the previous owner; a lone request wins outright
  always_comb begin
    owner_o = OWN_CORE;
    if (core_req_i && dma_req_i) begin
      owner_o = ~last_owner_i;
    end else if (dma_req_i) begin
      owner_o = OWN_DMA;
    end
  end
`else
  // Fixed priority: history is irrelevant, so the last-owner input is intentionally ignored
  logic w_unused_last_owner;
  assign w_unused_last_owner = last_owner_i;

  // Core wins whenever it asks; DMA only gets the bus when the core is quiet
  always_comb begin
    owner_o = OWN_CORE;
    if (!core_req_i && dma_req_i) begin
      owner_o = OWN_DMA;
    end
  end
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_bus_arbiter                                           |
// | Brief    : Two-master (core / DMA) arbiter for the data memory bus.  |
// |            Each access is latched at grant, then walks ISSUE, WAIT   |
// |            and DONE. Optional macro ARB_ROUND_ROBIN_EN selects       |
// |            round-robin arbitration instead of core-first priority.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  // core datapath port
  input  logic        iCoreRead,
  input  logic        iCoreWrite,
  input  logic [3:0]  iCoreByteEnable,
  input  logic [31:0] iCoreAddress,
  input  logic [31:0] iCoreWriteData,
  output logic [31:0] oCoreReadData,
  output logic        oCoreStall,
  // DMA / debug port
  input  logic        iDmaReq,
  input  logic        iDmaWrite,
  input  logic [3:0]  iDmaByteEnable,
  input  logic [31:0] iDmaAddress,
  input  logic [31:0] iDmaWriteData,
  output logic        oDmaAck,
  output logic [31:0] oDmaReadData,
  // system bus
  output logic        oBusReadEnable,
  output logic        oBusWriteEnable,
  output logic [3:0]  oBusByteEnable,
  output logic [31:0] oBusAddress,
  output logic [31:0] oBusWriteData,
  input  logic [31:0] iBusReadData
);

  // Latency clamped to what the counter can hold
  localparam logic [CNT_W-1:0] c_WAIT_LOAD =
    (WAIT_CYCLES > WAIT_CYCLES_MAX) ? CNT_W'(WAIT_CYCLES_MAX) : CNT_W'(WAIT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic             owner_q;
  bus_req_t         req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      core_rdata_q;
  logic [31:0]      dma_rdata_q;

  logic     w_core_req;
  logic     w_any_req;
  logic     w_pick_owner;
  logic     w_last_owner;
  logic     w_issue;
  logic     w_last_phase;
  bus_req_t w_grant_req;

  assign w_core_req = iCoreRead | iCoreWrite;
  assign w_any_req  = w_core_req | iDmaReq;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  // Remember who was granted most recently so contention can alternate
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      last_owner_q <= OWN_DMA;
    end else if (state_q == IDLE && w_any_req) begin
      last_owner_q <= w_pick_owner;
    end
  end

  assign w_last_owner = last_owner_q;
`else
  assign w_last_owner = OWN_DMA;
`endif

  mem_arb_pick u_pick (
    .core_req_i   (w_core_req),
    .dma_req_i    (iDmaReq),
    .last_owner_i (w_last_owner),
    .owner_o      (w_pick_owner)
  );

  // Request of the selected master; a core read+write collapses to a write
  always_comb begin
    if (w_pick_owner == OWN_CORE) begin
      w_grant_req = '{wr: iCoreWrite, be: iCoreByteEnable,
                      addr: iCoreAddress, wdata: iCoreWriteData};
    end else begin
      w_grant_req = '{wr: iDmaWrite, be: iDmaByteEnable,
                      addr: iDmaAddress, wdata: iDmaWriteData};
    end
  end

  // Next-state logic: one ISSUE cycle, optional wait states, one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_any_req) state_d = ISSUE;
      ISSUE:   state_d = (c_WAIT_LOAD != '0) ? WAIT : DONE;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, owner and request capture, wait counter
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && w_any_req) begin
        owner_q <= w_pick_owner;
        req_q   <= w_grant_req;
      end
      if (state_q == ISSUE) begin
        cnt_q <= c_WAIT_LOAD;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Bus data is taken on the edge that closes the final ISSUE/WAIT cycle
  assign w_last_phase = ((state_q == ISSUE) && (c_WAIT_LOAD == '0)) ||
                        ((state_q == WAIT)  && (cnt_q == CNT_W'(1)));

  // Read-data registers: only completed reads of the respective owner update them
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else if (w_last_phase && !req_q.wr) begin
      if (owner_q == OWN_CORE) begin
        core_rdata_q <= iBusReadData;
      end else begin
        dma_rdata_q  <= iBusReadData;
      end
    end
  end

  assign w_issue         = (state_q == ISSUE);
  assign oBusReadEnable  = w_issue & ~req_q.wr;
  assign oBusWriteEnable = w_issue &  req_q.wr;
  assign oBusByteEnable  = {4{w_issue}}  & req_q.be;
  assign oBusAddress     = {32{w_issue}} & req_q.addr;
  assign oBusWriteData   = {32{w_issue}} & req_q.wdata;

  assign oCoreReadData = core_rdata_q;
  assign oDmaReadData  = dma_rdata_q;
  assign oDmaAck       = (state_q == DONE) && (owner_q == OWN_DMA);
  // Combinational so an idle core is never held, including during reset
  assign oCoreStall    = w_core_req & ~((state_q == DONE) && (owner_q == OWN_CORE));

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mem_bus_arbiter                                        |
// | Brief    : Directed self-checking bench for mem_bus_arbiter, with    |
// |            extra instances at WAIT_CYCLES=0 and 15 for latency.      |
// |            Expectations follow ARB_ROUND_ROBIN_EN when defined.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iCoreRead, iCoreWrite;
  logic [3:0]  iCoreByteEnable;
  logic [31:0] iCoreAddress, iCoreWriteData;
  logic        iDmaReq, iDmaWrite;
  logic [3:0]  iDmaByteEnable;
  logic [31:0] iDmaAddress, iDmaWriteData;
  logic [31:0] iBusReadData;

  logic [31:0] oCoreReadData, oDmaReadData, oBusAddress, oBusWriteData;
  logic        oCoreStall, oDmaAck, oBusReadEnable, oBusWriteEnable;
  logic [3:0]  oBusByteEnable;

  logic [31:0] z0_crd, z0_drd, z0_addr, z0_wd;
  logic        z0_stall, z0_ack, z0_re, z0_we;
  logic [3:0]  z0_be;
  logic [31:0] z15_crd, z15_drd, z15_addr, z15_wd;
  logic        z15_stall, z15_ack, z15_re, z15_we;
  logic [3:0]  z15_be;

  int total = 0;
  int bad   = 0;

  always #5 iCLK = ~iCLK;

  mem_bus_arbiter #(.WAIT_CYCLES(1)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iCoreRead(iCoreRead), .iCoreWrite(iCoreWrite), .iCoreByteEnable(iCoreByteEnable),
    .iCoreAddress(iCoreAddress), .iCoreWriteData(iCoreWriteData),
    .oCoreReadData(oCoreReadData), .oCoreStall(oCoreStall),
    .iDmaReq(iDmaReq), .iDmaWrite(iDmaWrite), .iDmaByteEnable(iDmaByteEnable),
    .iDmaAddress(iDmaAddress), .iDmaWriteData(iDmaWriteData),
    .oDmaAck(oDmaAck), .oDmaReadData(oDmaReadData),
    .oBusReadEnable(oBusReadEnable), .oBusWriteEnable(oBusWriteEnable),
    .oBusByteEnable(oBusByteEnable), .oBusAddress(oBusAddress),
    .oBusWriteData(oBusWriteData), .iBusReadData(iBusReadData)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
    .iCLK(iCLK), .iRST(iRST),
    .iCoreRead(iCoreRead), .iCoreWrite(iCoreWrite), .iCoreByteEnable(iCoreByteEnable),
    .iCoreAddress(iCoreAddress), .iCoreWriteData(iCoreWriteData),
    .oCoreReadData(z0_crd), .oCoreStall(z0_stall),
    .iDmaReq(iDmaReq), .iDmaWrite(iDmaWrite), .iDmaByteEnable(iDmaByteEnable),
    .iDmaAddress(iDmaAddress), .iDmaWriteData(iDmaWriteData),
    .oDmaAck(z0_ack), .oDmaReadData(z0_drd),
    .oBusReadEnable(z0_re), .oBusWriteEnable(z0_we),
    .oBusByteEnable(z0_be), .oBusAddress(z0_addr),
    .oBusWriteData(z0_wd), .iBusReadData(iBusReadData)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .iCLK(iCLK), .iRST(iRST),
    .iCoreRead(iCoreRead), .iCoreWrite(iCoreWrite), .iCoreByteEnable(iCoreByteEnable),
    .iCoreAddress(iCoreAddress), .iCoreWriteData(iCoreWriteData),
    .oCoreReadData(z15_crd), .oCoreStall(z15_stall),
    .iDmaReq(iDmaReq), .iDmaWrite(iDmaWrite), .iDmaByteEnable(iDmaByteEnable),
    .iDmaAddress(iDmaAddress), .iDmaWriteData(iDmaWriteData),
    .oDmaAck(z15_ack), .oDmaReadData(z15_drd),
    .oBusReadEnable(z15_re), .oBusWriteEnable(z15_we),
    .oBusByteEnable(z15_be), .oBusAddress(z15_addr),
    .oBusWriteData(z15_wd), .iBusReadData(iBusReadData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, plus settling time
  task automatic step();
    @(negedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    step();
    iRST = 1'b1;
    step();
    iRST = 1'b0;
  endtask

  logic [2:0] exp_own;
  int         ack_count;
  int         d0, d1, d15;

  initial begin
    iCoreRead = 0; iCoreWrite = 0; iCoreByteEnable = 0; iCoreAddress = 0; iCoreWriteData = 0;
    iDmaReq = 0; iDmaWrite = 0; iDmaByteEnable = 0; iDmaAddress = 0; iDmaWriteData = 0;
    iBusReadData = 0;

    // ---------------- reset values ----------------
    #1 iRST = 1'b1;
    #2;
    chk("rst state", 32'(dut.state_q), 32'd0);
    chk("rst rd_en", 32'(oBusReadEnable), 32'd0);
    chk("rst wr_en", 32'(oBusWriteEnable), 32'd0);
    chk("rst addr", oBusAddress, 32'd0);
    chk("rst ack", 32'(oDmaAck), 32'd0);
    chk("rst core_rd", oCoreReadData, 32'd0);
    chk("rst dma_rd", oDmaReadData, 32'd0);
    chk("rst stall idle", 32'(oCoreStall), 32'd0);
    chk("rst w0 outs", 32'(|{z0_crd, z0_drd, z0_addr, z0_wd, z0_stall, z0_ack, z0_re, z0_we, z0_be}), 32'd0);
    chk("rst w15 outs", 32'(|{z15_crd, z15_drd, z15_addr, z15_wd, z15_stall, z15_ack, z15_re, z15_we, z15_be}), 32'd0);
    iCoreRead = 1'b1;
    #1 chk("rst stall follows req", 32'(oCoreStall), 32'd1);
    iCoreRead = 1'b0;
    step();
    step();
    iRST = 1'b0;

    // ---------------- core read 0x1000 ----------------
    step();
    iBusReadData = 32'hDEADBEEF; iCoreAddress = 32'h1000; iCoreByteEnable = 4'hF; iCoreRead = 1'b1;
    #1;
    chk("rd t stall", 32'(oCoreStall), 32'd1);
    chk("rd t rd_en", 32'(oBusReadEnable), 32'd0);
    step();
    chk("rd t+1 rd_en", 32'(oBusReadEnable), 32'd1);
    chk("rd t+1 wr_en", 32'(oBusWriteEnable), 32'd0);
    chk("rd t+1 addr", oBusAddress, 32'h1000);
    chk("rd t+1 stall", 32'(oCoreStall), 32'd1);
    step();
    chk("rd t+2 rd_en", 32'(oBusReadEnable), 32'd0);
    chk("rd t+2 addr", oBusAddress, 32'd0);
    chk("rd t+2 stall", 32'(oCoreStall), 32'd1);
    step();
    chk("rd t+3 stall", 32'(oCoreStall), 32'd0);
    chk("rd t+3 data", oCoreReadData, 32'hDEADBEEF);
    chk("rd t+3 state", 32'(dut.state_q), 32'd3);
    iCoreRead = 1'b0;
    step();
    chk("rd t+4 state", 32'(dut.state_q), 32'd0);
    chk("rd t+4 stall", 32'(oCoreStall), 32'd0);

    // ---------------- core write 0x2004 (read also high: write wins) ----------------
    iBusReadData = 32'hCAFEF00D; iCoreAddress = 32'h2004; iCoreWriteData = 32'h12345678;
    iCoreByteEnable = 4'b0011; iCoreWrite = 1'b1; iCoreRead = 1'b1;
    step();
    chk("wr t+1 wr_en", 32'(oBusWriteEnable), 32'd1);
    chk("wr t+1 rd_en", 32'(oBusReadEnable), 32'd0);
    chk("wr t+1 addr", oBusAddress, 32'h2004);
    chk("wr t+1 data", oBusWriteData, 32'h12345678);
    chk("wr t+1 be", 32'(oBusByteEnable), 32'h3);
    step();
    chk("wr t+2 wr_en", 32'(oBusWriteEnable), 32'd0);
    chk("wr t+2 stall", 32'(oCoreStall), 32'd1);
    step();
    chk("wr t+3 stall", 32'(oCoreStall), 32'd0);
    chk("wr t+3 core_rd kept", oCoreReadData, 32'hDEADBEEF);
    iCoreWrite = 1'b0; iCoreRead = 1'b0;

    // ---------------- simultaneous requests, three rounds ----------------
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = 3'b010;
`else
    exp_own = 3'b000;
`endif
    ack_count = 0;
    iBusReadData = 32'h0BADF00D;
    iCoreAddress = 32'h5000; iCoreByteEnable = 4'hF; iCoreRead = 1'b1;
    iDmaAddress = 32'h6000; iDmaByteEnable = 4'hF; iDmaWrite = 1'b0; iDmaReq = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) #1;
      else step();
      if (oDmaAck) ack_count++;
      if (k % 4 == 0)
        chk($sformatf("arb r%0d idle", k / 4), 32'(dut.state_q), 32'd0);
      if (k % 4 == 1)
        chk($sformatf("arb r%0d addr", k / 4), oBusAddress,
            exp_own[k / 4] ? 32'h6000 : 32'h5000);
      if (k % 4 == 3) begin
        chk($sformatf("arb r%0d ack", k / 4), 32'(oDmaAck), 32'(exp_own[k / 4]));
        chk($sformatf("arb r%0d stall", k / 4), 32'(oCoreStall), 32'(exp_own[k / 4]));
      end
    end
    iCoreRead = 1'b0; iDmaReq = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb ack count", 32'(ack_count), 32'd1);
    chk("arb dma data", oDmaReadData, 32'h0BADF00D);
`else
    chk("arb ack count", 32'(ack_count), 32'd0);
    chk("arb dma data", oDmaReadData, 32'd0);
`endif
    step();

    // ---------------- DMA read 0x3000 with address change after grant ----------------
    iBusReadData = 32'h55AA33CC; iDmaAddress = 32'h3000; iDmaWrite = 1'b0; iDmaReq = 1'b1;
    step();
    iDmaAddress = 32'h4000; iDmaWrite = 1'b1;
    #1;
    chk("dma t+1 rd_en", 32'(oBusReadEnable), 32'd1);
    chk("dma t+1 addr", oBusAddress, 32'h3000);
    step();
    chk("dma t+2 ack", 32'(oDmaAck), 32'd0);
    step();
    chk("dma t+3 ack", 32'(oDmaAck), 32'd1);
    chk("dma t+3 data", oDmaReadData, 32'h55AA33CC);
    chk("dma t+3 core_rd kept", oCoreReadData, 32'h0BADF00D);
    iDmaReq = 1'b0; iDmaWrite = 1'b0; iBusReadData = 32'h0;
    step();
    chk("dma t+4 ack", 32'(oDmaAck), 32'd0);
    chk("dma t+4 data held", oDmaReadData, 32'h55AA33CC);
    chk("dma t+4 state", 32'(dut.state_q), 32'd0);

    // ---------------- reset during WAIT of a DMA read ----------------
    iBusReadData = 32'h11112222; iDmaAddress = 32'h3000; iDmaReq = 1'b1;
    step();
    step();
    chk("rstw pre state", 32'(dut.state_q), 32'd2);
    iRST = 1'b1; iCoreRead = 1'b1;
    #1;
    chk("rstw state", 32'(dut.state_q), 32'd0);
    chk("rstw strobes", 32'({oBusReadEnable, oBusWriteEnable}), 32'd0);
    chk("rstw addr", oBusAddress, 32'd0);
    chk("rstw ack", 32'(oDmaAck), 32'd0);
    chk("rstw dma_rd", oDmaReadData, 32'd0);
    chk("rstw core_rd", oCoreReadData, 32'd0);
    chk("rstw stall req", 32'(oCoreStall), 32'd1);
    iCoreRead = 1'b0;
    #1 chk("rstw stall noreq", 32'(oCoreStall), 32'd0);
    step();
    chk("rstw held ack", 32'(oDmaAck), 32'd0);
    iRST = 1'b0; iBusReadData = 32'h77665544;
    step();
    chk("post r+1 rd_en", 32'(oBusReadEnable), 32'd1);
    chk("post r+1 addr", oBusAddress, 32'h3000);
    step();
    chk("post r+2 ack", 32'(oDmaAck), 32'd0);
    step();
    chk("post r+3 ack", 32'(oDmaAck), 32'd1);
    chk("post r+3 data", oDmaReadData, 32'h77665544);
    iDmaReq = 1'b0;
    step();

    // ---------------- latency for WAIT_CYCLES = 1, 0, 15 ----------------
    do_reset();
    iCoreAddress = 32'h100; iCoreRead = 1'b1;
    d0 = -1; d1 = -1; d15 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!oCoreStall && d1 < 0)  d1  = k;
      if (!z0_stall   && d0 < 0)  d0  = k;
      if (!z15_stall  && d15 < 0) d15 = k;
    end
    iCoreRead = 1'b0;
    chk("lat W1 done", 32'(d1), 32'd3);
    chk("lat W0 done", 32'(d0), 32'd2);
    chk("lat W15 done", 32'(d15), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
